// File: rtl/adder_cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_cla_pkg
// Description : Shared constants and helpers for the pipelined CLA adder.
//               CLA_GW     - carry-lookahead group width in bits
//               MAX_NSTAGE - largest supported pipeline depth
//               slice_width() - per-stage slice width for a BW/NSTAGE pair
// Revision    : 1.0 - initial release
// ============================================================================
package adder_cla_pkg;

  localparam int CLA_GW     = 4;
  localparam int MAX_NSTAGE = 8;

  function automatic int slice_width(input int bw, input int nstage);
    return bw / nstage;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_cla_slice.sv
`default_nettype none
// ============================================================================
// Module      : adder_cla_slice
// Description : Combinational SW-bit carry-lookahead adder built from 4-bit
//               group generate/propagate terms.
// Ports       : i_a [SW]  operand A slice
//               i_b [SW]  operand B slice
//               i_c       carry-in
//               o_s [SW]  sum slice
//               o_c       carry-out
// Parameters  : SW - slice width, a multiple of CLA_GW
// Revision    : 1.0 - initial release
// ============================================================================
module adder_cla_slice
  import adder_cla_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_c,
  output logic [SW-1:0] o_s,
  output logic          o_c
);

  localparam int NG = SW / CLA_GW;

  logic [SW-1:0] gen;
  logic [SW-1:0] prop;
  logic [SW-1:0] bit_cin;
  logic [NG-1:0] grp_gen;
  logic [NG-1:0] grp_prop;
  logic [NG-1:0] grp_cin;
  logic          slice_cout;

  assign gen  = i_a & i_b;
  assign prop = i_a ^ i_b;

  generate
    for (genvar j = 0; j < NG; j++) begin : g_grp
      localparam int B = j * CLA_GW;

      assign grp_gen[j]  = gen[B+3]
                         | (prop[B+3] & gen[B+2])
                         | (prop[B+3] & prop[B+2] & gen[B+1])
                         | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
      assign grp_prop[j] = &prop[B +: CLA_GW];

      // Bit carries inside the group are fully flattened from the group carry-in.
      assign bit_cin[B]   = grp_cin[j];
      assign bit_cin[B+1] = gen[B] | (prop[B] & grp_cin[j]);
      assign bit_cin[B+2] = gen[B+1]
                          | (prop[B+1] & gen[B])
                          | (prop[B+1] & prop[B] & grp_cin[j]);
      assign bit_cin[B+3] = gen[B+2]
                          | (prop[B+2] & gen[B+1])
                          | (prop[B+2] & prop[B+1] & gen[B])
                          | (prop[B+2] & prop[B+1] & prop[B] & grp_cin[j]);
    end
  endgenerate

  // Group-level carry chain; a local variable keeps the recurrence acyclic.
  always_comb begin
    logic carry;
    carry   = i_c;
    grp_cin = '0;
    for (int j = 0; j < NG; j++) begin
      grp_cin[j] = carry;
      carry      = grp_gen[j] | (grp_prop[j] & carry);
    end
    slice_cout = carry;
  end

  assign o_s = prop ^ bit_cin;
  assign o_c = slice_cout;

endmodule
`default_nettype wire

// File: rtl/adder_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_cla_pipe
// Description : Pipelined carry-lookahead adder with valid/ready handshake.
//               Operands are split into NSTAGE slices of SW = BW/NSTAGE bits;
//               stage k adds slice k and registers its carry into stage k+1.
//               One result per cycle, latency NSTAGE, no skid buffer.
// Ports       : i_clk, i_rst     clock, synchronous active-high reset
//               i_vld / o_rdy    input handshake
//               i_a, i_b, i_c    operands and carry-in
//               o_vld / i_rdy    output handshake
//               o_s, o_c         sum and carry-out of a+b+c
//               o_ovf            signed overflow (ADDER_CLA_PIPE_OVF_EN only)
// Macro       : ADDER_CLA_PIPE_OVF_EN enables the o_ovf port and logic.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_cla_pipe
  import adder_cla_pkg::*;
#(
  parameter int BW     = 32,
  parameter int NSTAGE = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  input  logic          i_c,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [BW-1:0] o_s,
  output logic          o_c
`ifdef ADDER_CLA_PIPE_OVF_EN
  ,
  output logic          o_ovf
`endif
);

  localparam int SW = slice_width(BW, NSTAGE);

  // Per-stage state. acc_q holds finished sum slices below the raw upper
  // slices of A; bop_q holds the still-unconsumed upper slices of B.
  logic [NSTAGE-1:0] vld;
  logic [BW-1:0]     acc_q [NSTAGE];
  logic [BW-1:0]     bop_q [NSTAGE];
  logic [NSTAGE-1:0] cry_q;

  // Per-stage inputs and next values.
  logic [BW-1:0]     acc_in [NSTAGE];
  logic [BW-1:0]     bop_in [NSTAGE];
  logic [NSTAGE-1:0] cry_in;
  logic [NSTAGE-1:0] vld_in;
  logic [BW-1:0]     acc_d  [NSTAGE];
  logic [BW-1:0]     bop_d  [NSTAGE];
  logic [NSTAGE-1:0] cry_d;

  logic [NSTAGE:0]   rdy;

  // Ready chain from the consumer back to the input: a stage can load when
  // it is empty or when the stage after it is moving.
  always_comb begin
    rdy         = '0;
    rdy[NSTAGE] = i_rdy;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  generate
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      logic [SW-1:0] slice_sum;
      logic          slice_cout;
      logic [BW-1:0] acc_nx;
      logic [BW-1:0] bop_nx;

      if (k == 0) begin : g_first
        assign acc_in[k] = i_a;
        assign bop_in[k] = i_b;
        assign cry_in[k] = i_c;
        assign vld_in[k] = i_vld;
      end else begin : g_next
        assign acc_in[k] = acc_q[k-1];
        assign bop_in[k] = bop_q[k-1];
        assign cry_in[k] = cry_q[k-1];
        assign vld_in[k] = vld[k-1];
      end

      adder_cla_slice #(
        .SW (SW)
      ) u_slice (
        .i_a (acc_in[k][k*SW +: SW]),
        .i_b (bop_in[k][k*SW +: SW]),
        .i_c (cry_in[k]),
        .o_s (slice_sum),
        .o_c (slice_cout)
      );

      // Replace slice k of A with its sum; slice k of B is consumed.
      always_comb begin
        acc_nx                = acc_in[k];
        acc_nx[k*SW +: SW]    = slice_sum;
        bop_nx                = bop_in[k];
        bop_nx[k*SW +: SW]    = '0;
      end

      assign acc_d[k] = acc_nx;
      assign bop_d[k] = bop_nx;
      assign cry_d[k] = slice_cout;
    end
  endgenerate

`ifdef ADDER_CLA_PIPE_OVF_EN
  // The top slice stays raw until the last stage, so the operand MSBs ride
  // along in acc_q/bop_q and are still visible at the last stage's inputs.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (acc_in[NSTAGE-1][BW-1] == bop_in[NSTAGE-1][BW-1])
              && (acc_d[NSTAGE-1][BW-1] != acc_in[NSTAGE-1][BW-1]);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld   <= '0;
      cry_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
`ifdef ADDER_CLA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (rdy[k]) begin
          vld[k]   <= vld_in[k];
          acc_q[k] <= acc_d[k];
          bop_q[k] <= bop_d[k];
          cry_q[k] <= cry_d[k];
        end
      end
`ifdef ADDER_CLA_PIPE_OVF_EN
      if (rdy[NSTAGE-1]) begin
        ovf_q <= ovf_d;
      end
`endif
    end
  end

  assign o_rdy = rdy[0];
  assign o_vld = vld[NSTAGE-1];
  assign o_s   = acc_q[NSTAGE-1];
  assign o_c   = cry_q[NSTAGE-1];
`ifdef ADDER_CLA_PIPE_OVF_EN
  assign o_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_cla_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_adder_cla_pipe
// Description : Self-checking bench for adder_cla_pipe. A queue-based model
//               predicts every accepted sum from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_cla_pipe;

  localparam int BW = 32;
  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic          cin;
  logic          out_vld;
  logic          out_rdy;
  logic [BW-1:0] sum;
  logic          cout;
`ifdef ADDER_CLA_PIPE_OVF_EN
  logic          ovf;
  logic          ovf1, ovf8, ovf64;
`endif

  // Parameter-sweep instances share clock, reset and handshake stimulus.
  logic          sw_vld;
  logic [31:0]   sw_a32, sw_b32;
  logic [63:0]   sw_a64, sw_b64;
  logic          rdy1, rdy8, rdy64;
  logic          vld1, vld8, vld64;
  logic [31:0]   s1, s8;
  logic [63:0]   s64;
  logic          c1, c8, c64;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  adder_cla_pipe #(.BW(BW), .NSTAGE(NS)) u_dut (
    .i_clk (clk), .i_rst (rst), .i_vld (in_vld), .o_rdy (in_rdy),
    .i_a (a), .i_b (b), .i_c (cin),
    .o_vld (out_vld), .i_rdy (out_rdy), .o_s (sum), .o_c (cout)
`ifdef ADDER_CLA_PIPE_OVF_EN
    , .o_ovf (ovf)
`endif
  );

  adder_cla_pipe #(.BW(32), .NSTAGE(1)) u_n1 (
    .i_clk (clk), .i_rst (rst), .i_vld (sw_vld), .o_rdy (rdy1),
    .i_a (sw_a32), .i_b (sw_b32), .i_c (1'b1),
    .o_vld (vld1), .i_rdy (1'b1), .o_s (s1), .o_c (c1)
`ifdef ADDER_CLA_PIPE_OVF_EN
    , .o_ovf (ovf1)
`endif
  );

  adder_cla_pipe #(.BW(32), .NSTAGE(8)) u_n8 (
    .i_clk (clk), .i_rst (rst), .i_vld (sw_vld), .o_rdy (rdy8),
    .i_a (sw_a32), .i_b (sw_b32), .i_c (1'b1),
    .o_vld (vld8), .i_rdy (1'b1), .o_s (s8), .o_c (c8)
`ifdef ADDER_CLA_PIPE_OVF_EN
    , .o_ovf (ovf8)
`endif
  );

  adder_cla_pipe #(.BW(64), .NSTAGE(4)) u_w64 (
    .i_clk (clk), .i_rst (rst), .i_vld (sw_vld), .o_rdy (rdy64),
    .i_a (sw_a64), .i_b (sw_b64), .i_c (1'b1),
    .o_vld (vld64), .i_rdy (1'b1), .o_s (s64), .o_c (c64)
`ifdef ADDER_CLA_PIPE_OVF_EN
    , .o_ovf (ovf64)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [BW-1:0] s;
    logic          c;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];

  function automatic exp_t model(input logic [BW-1:0] x, input logic [BW-1:0] y, input logic ci);
    exp_t        e;
    longint      uns;
    longint      sgn;
    uns   = longint'({32'b0, x}) + longint'({32'b0, y}) + longint'(ci);
    sgn   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    e.s   = uns[BW-1:0];
    e.c   = uns[BW];
    e.ovf = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
    return e;
  endfunction

  int            cyc = 0;
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_s;
  logic          prev_c;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_vld", {63'b0, out_vld}, 64'd1);
        check("stall_sum", {32'b0, sum}, {32'b0, prev_s});
        check("stall_cout", {63'b0, cout}, {63'b0, prev_c});
      end
      if (out_vld) check("out_has_expect", {63'b0, q.size() > 0}, 64'd1);
      if (out_vld && out_rdy && q.size() > 0) begin
        e = q.pop_front();
        check("sum", {32'b0, sum}, {32'b0, e.s});
        check("cout", {63'b0, cout}, {63'b0, e.c});
`ifdef ADDER_CLA_PIPE_OVF_EN
        check("ovf", {63'b0, ovf}, {63'b0, e.ovf});
`endif
        pop_cyc.push_back(cyc);
      end
      if (in_vld && in_rdy) q.push_back(model(a, b, cin));
      prev_hold = out_vld && !out_rdy;
      prev_s    = sum;
      prev_c    = cout;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the operands already on the bus, then counts cycles from the
  // accept edge until o_vld is seen.
  task automatic wait_out(output int n);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, p0, l1, l8, l64;
    logic acc;
    rst = 1'b1; in_vld = 1'b0; a = '0; b = '0; cin = 1'b0; out_rdy = 1'b1;
    sw_vld = 1'b0; sw_a32 = '0; sw_b32 = '0; sw_a64 = '0; sw_b64 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", {63'b0, out_vld}, 64'd0);
    check("rst_sum", {32'b0, sum}, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
`ifdef ADDER_CLA_PIPE_OVF_EN
    check("rst_ovf", {63'b0, ovf}, 64'd0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {63'b0, in_rdy}, 64'd1);

    // Maximum carry propagation
    tick();
    in_vld = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1;
    wait_out(n);
    check("lat_maxcarry", 64'(n), 64'(NS));
    check("maxcarry_sum", {32'b0, sum}, 64'd0);
    check("maxcarry_cout", {63'b0, cout}, 64'd1);
    repeat (NS) tick();

    // Back-to-back streaming
    p0 = pop_cyc.size();
    for (int i = 0; i < 20; i++) begin
      in_vld = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom % 2);
      tick();
    end
    in_vld = 1'b0;
    repeat (NS + 2) tick();
    check("stream_count", 64'(pop_cyc.size() - p0), 64'd20);
    if (pop_cyc.size() - p0 == 20)
      check("stream_span", 64'(pop_cyc[p0+19] - pop_cyc[p0]), 64'd19);

    // Backpressure: fill with output stalled
    out_rdy = 1'b0;
    for (int i = 0; i < NS; i++) begin
      in_vld = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom % 2);
      tick();
    end
    a = $urandom; b = $urandom; cin = 1'($urandom % 2);
    @(negedge clk);
    check("full_rdy", {63'b0, in_rdy}, 64'd0);
    check("full_vld", {63'b0, out_vld}, 64'd1);
    tick();
    tick();
    @(negedge clk);
    check("full_rdy_hold", {63'b0, in_rdy}, 64'd0);
    tick();
    out_rdy = 1'b1;
    @(negedge clk);
    check("rdy_follows", {63'b0, in_rdy}, 64'd1);
    tick();
    in_vld = 1'b0;
    repeat (NS + 2) tick();
    check("bp_drained", 64'(q.size()), 64'd0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk);
      #1;
      if (acc || !in_vld) begin
        in_vld = ($urandom % 10) < 7;
        a = $urandom; b = $urandom; cin = 1'($urandom % 2);
      end
      out_rdy = ($urandom % 10) < 6;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (NS + 2) tick();
    check("rand_drained", 64'(q.size()), 64'd0);

    // Reset with two items in flight
    in_vld = 1'b1; a = $urandom; b = $urandom; cin = 1'b0;
    tick();
    a = $urandom; b = $urandom;
    tick();
    rst = 1'b1; a = 32'd1; b = 32'd1;
    tick();
    rst = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    check("midrst_vld", {63'b0, out_vld}, 64'd0);
    check("midrst_sum", {32'b0, sum}, 64'd0);
    check("midrst_cout", {63'b0, cout}, 64'd0);
    repeat (NS + 2) tick();
    in_vld = 1'b1; a = 32'd5; b = 32'd3; cin = 1'b0;
    wait_out(n);
    check("lat_after_rst", 64'(n), 64'(NS));
    check("after_rst_sum", {32'b0, sum}, 64'd8);
    repeat (NS) tick();

`ifdef ADDER_CLA_PIPE_OVF_EN
    // Signed overflow
    in_vld = 1'b1; a = 32'h7FFF_FFFF; b = 32'd1; cin = 1'b0;
    wait_out(n);
    check("ovf_pos", {63'b0, ovf}, 64'd1);
    check("ovf_pos_sum", {32'b0, sum}, 64'h8000_0000);
    check("ovf_pos_cout", {63'b0, cout}, 64'd0);
    tick();
    in_vld = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
    wait_out(n);
    check("ovf_neg", {63'b0, ovf}, 64'd1);
    check("ovf_neg_sum", {32'b0, sum}, 64'd0);
    check("ovf_neg_cout", {63'b0, cout}, 64'd1);
    repeat (NS) tick();
`endif

    // Parameter sweep: alternating-bit operands plus carry-in wrap to zero
    check("n1_rdy", {63'b0, rdy1}, 64'd1);
    check("n8_rdy", {63'b0, rdy8}, 64'd1);
    check("w64_rdy", {63'b0, rdy64}, 64'd1);
    sw_vld = 1'b1;
    sw_a32 = 32'hAAAA_AAAA; sw_b32 = 32'h5555_5555;
    sw_a64 = 64'hAAAA_AAAA_AAAA_AAAA; sw_b64 = 64'h5555_5555_5555_5555;
    @(posedge clk);
    #1;
    sw_vld = 1'b0;
    l1 = 0; l8 = 0; l64 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (vld1 && l1 == 0) begin
        l1 = i;
        check("n1_sum", {32'b0, s1}, 64'd0);
        check("n1_cout", {63'b0, c1}, 64'd1);
      end
      if (vld8 && l8 == 0) begin
        l8 = i;
        check("n8_sum", {32'b0, s8}, 64'd0);
        check("n8_cout", {63'b0, c8}, 64'd1);
      end
      if (vld64 && l64 == 0) begin
        l64 = i;
        check("w64_sum", s64, 64'd0);
        check("w64_cout", {63'b0, c64}, 64'd1);
      end
    end
    check("n1_lat", 64'(l1), 64'd1);
    check("n8_lat", 64'(l8), 64'd8);
    check("w64_lat", 64'(l64), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
